// File: rtl/act_mem_ext_dma.sv
// Host-side DMA for the activation memory external port: packs a load element
// stream into rows for writing, and serializes read rows onto a store stream.
//
// state     | meaning
// S_IDLE    | waiting for a command, cmd_ready high
// S_LOAD    | accepting load elements, packing rows, launching writes
// S_ST_RD   | read strobe for the current row
// S_ST_CAP  | capture the returned row into the unload buffer
// S_ST_SEND | serializing the unload buffer onto the store stream
// S_DONE    | one-cycle completion pulse
module act_mem_ext_dma #(
  parameter int N_DIM_ARRAY    = 8,
  parameter int ACT_DATA_WIDTH = 8,
  parameter int ADDR_WIDTH     = 12,
  parameter int LEN_WIDTH      = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 i_cmd_valid,
  output logic                                 o_cmd_ready,
  input  logic                                 i_cmd_dir,
  input  logic [ADDR_WIDTH-1:0]                i_cmd_base_addr,
  input  logic [LEN_WIDTH-1:0]                 i_cmd_len,
  input  logic                                 i_s_valid,
  input  logic [ACT_DATA_WIDTH-1:0]            i_s_data,
  output logic                                 o_s_ready,
  output logic                                 o_m_valid,
  output logic [ACT_DATA_WIDTH-1:0]            o_m_data,
  output logic                                 o_m_last,
  input  logic                                 i_m_ready,
  output logic                                 o_wr_en_ext,
  output logic [ADDR_WIDTH-1:0]                o_wr_addr_ext,
  output logic [N_DIM_ARRAY*ACT_DATA_WIDTH-1:0] o_wr_data_ext,
  output logic                                 o_rd_en_ext,
  output logic [ADDR_WIDTH-1:0]                o_rd_addr_ext,
  input  logic [N_DIM_ARRAY*ACT_DATA_WIDTH-1:0] i_rd_data_ext,
  output logic                                 o_busy,
  output logic                                 o_done
);

  localparam int N_LOG = $clog2(N_DIM_ARRAY);
  localparam int W     = ACT_DATA_WIDTH;
  localparam int ROW_W = N_DIM_ARRAY * ACT_DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(N_DIM_ARRAY - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP   = ADDR_WIDTH'(N_DIM_ARRAY);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ST_RD, S_ST_CAP, S_ST_SEND, S_DONE
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_row_cnt;
  logic [N_LOG-1:0]      r_lane_cnt;
  logic [ROW_W-1:0]      r_pack;
  logic [ROW_W-1:0]      r_unload;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [ROW_W-1:0]      r_wr_data;
  logic                  r_rd_en;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic                  r_done;

  logic [ADDR_WIDTH-1:0] w_row_addr;
  logic                  w_last_lane;
  logic                  w_last_row;

  // Address arithmetic wraps modulo 2^ADDR_WIDTH; the memory routes by MSB.
  assign w_row_addr  = r_base + ADDR_WIDTH'(r_row_cnt << N_LOG);
  assign w_last_lane = (r_lane_cnt == N_LOG'(N_DIM_ARRAY - 1));
  assign w_last_row  = (r_row_cnt == r_len - LEN_WIDTH'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_len      <= '0;
      r_row_cnt  <= '0;
      r_lane_cnt <= '0;
      r_pack     <= '0;
      r_unload   <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_rd_en    <= 1'b0;
      r_rd_addr  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_rd_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            r_base     <= i_cmd_base_addr & ALIGN_MASK;
            r_len      <= i_cmd_len;
            r_row_cnt  <= '0;
            r_lane_cnt <= '0;
            if (i_cmd_len == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else if (!i_cmd_dir) begin
              r_state <= S_LOAD;
            end else begin
              r_state   <= S_ST_RD;
              r_rd_en   <= 1'b1;
              r_rd_addr <= i_cmd_base_addr & ALIGN_MASK;
            end
          end
        end
        S_LOAD: begin
          if (i_s_valid) begin
            r_pack[r_lane_cnt*W +: W] <= i_s_data;
            r_lane_cnt                <= r_lane_cnt + N_LOG'(1);
            if (w_last_lane) begin
              // Incoming element bypasses the pack buffer so the row writes without a bubble.
              r_wr_data <= {i_s_data, r_pack[(N_DIM_ARRAY-1)*W-1:0]};
              r_wr_addr <= w_row_addr;
              r_wr_en   <= 1'b1;
              r_row_cnt <= r_row_cnt + LEN_WIDTH'(1);
              if (w_last_row) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
            end
          end
        end
        S_ST_RD: r_state <= S_ST_CAP;
        S_ST_CAP: begin
          r_unload   <= i_rd_data_ext;
          r_lane_cnt <= '0;
          r_state    <= S_ST_SEND;
        end
        S_ST_SEND: begin
          if (i_m_ready) begin
            r_lane_cnt <= r_lane_cnt + N_LOG'(1);
            if (w_last_lane) begin
              r_row_cnt <= r_row_cnt + LEN_WIDTH'(1);
              if (w_last_row) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state   <= S_ST_RD;
                r_rd_en   <= 1'b1;
                r_rd_addr <= w_row_addr + ROW_STEP;
              end
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_cmd_ready   = (r_state == S_IDLE);
  assign o_busy        = (r_state != S_IDLE);
  assign o_s_ready     = (r_state == S_LOAD);
  assign o_m_valid     = (r_state == S_ST_SEND);
  assign o_m_data      = r_unload[r_lane_cnt*W +: W];
  assign o_m_last      = o_m_valid && w_last_lane && w_last_row;
  assign o_wr_en_ext   = r_wr_en;
  assign o_wr_addr_ext = r_wr_addr;
  assign o_wr_data_ext = r_wr_data;
  assign o_rd_en_ext   = r_rd_en;
  assign o_rd_addr_ext = r_rd_addr;
  assign o_done        = r_done;

endmodule
